// File: rtl/obstacle_collide.sv
// obstacle_collide: collision, scoring and life/game-over control for the two-lane
// obstacle field on the 16x16 LED matrix.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   game_start         1-cycle pulse, starts a game from IDLE or OVER
//   start, gap         lane-1 obstacle column and gap code
//   start2, gap2       lane-2 obstacle column and gap code
//   player_row         player row, 0 = top
//   collide            1-cycle pulse per registered collision
//   score_pt           1-cycle pulse per score increment
//   score              score, binary or BCD
//   lives              remaining lives
//   hit_flash          high throughout the post-hit window
//   game_over          high once all lives are spent
//
// Build option: define COLLIDE_BCD_SCORE_EN for a two-digit BCD score (0..99);
// otherwise the score is an 8-bit binary count (0..255). Both saturate.
module obstacle_collide #(
  parameter logic [3:0]  PLAYER_COL = 4'd2,
  parameter int unsigned GAP_H      = 4,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned HIT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_start,
  input  logic [3:0] start,
  input  logic [2:0] gap,
  input  logic [3:0] start2,
  input  logic [2:0] gap2,
  input  logic [3:0] player_row,
  output logic       collide,
  output logic       score_pt,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       hit_flash,
  output logic       game_over
);

  localparam int unsigned     CntW     = (HIT_CYCLES > 1) ? $clog2(HIT_CYCLES) : 1;
  localparam logic [CntW-1:0] HitLast  = CntW'(HIT_CYCLES - 1);
  // Column one step past the player, wrapping at 16.
  localparam logic [3:0]      LeaveCol = PLAYER_COL + 4'd1;
`ifdef COLLIDE_BCD_SCORE_EN
  localparam logic [7:0]      ScoreMax = 8'h99;
`else
  localparam logic [7:0]      ScoreMax = 8'hFF;
`endif

  typedef enum logic [1:0] {StIdle, StPlay, StHit, StOver} state_e;

  state_e          state_q;
  logic [7:0]      score_q;
  logic [1:0]      lives_q;
  logic [CntW-1:0] cnt_q;
  logic            flag1_q, flag2_q;
  logic [3:0]      prev1_q, prev2_q;
  logic            collide_q, score_pt_q, hit_flash_q, game_over_q;

  logic       blk1, blk2, lv1, lv2, gain1, gain2, new_hit, scored;
  logic [7:0] score_nx;

  // Saturating single-step increment in the selected number format.
  function automatic logic [7:0] score_inc(input logic [7:0] s);
    if (s == ScoreMax) return s;
`ifdef COLLIDE_BCD_SCORE_EN
    if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
`else
    return s + 8'd1;
`endif
  endfunction

  // Open window spans rows 2*g .. 2*g+GAP_H-1; rows past 15 simply never match.
  function automatic logic row_open(input logic [3:0] row, input logic [2:0] g);
    logic [5:0] lo;
    logic [5:0] hi;
    lo = {2'b00, g, 1'b0};
    hi = lo + 6'(GAP_H) - 6'd1;
    return ({2'b00, row} >= lo) && ({2'b00, row} <= hi);
  endfunction

  always_comb begin
    blk1     = (start == PLAYER_COL) && !row_open(player_row, gap);
    blk2     = (start2 == PLAYER_COL) && !row_open(player_row, gap2);
    lv1      = (prev1_q == PLAYER_COL) && (start == LeaveCol);
    lv2      = (prev2_q == PLAYER_COL) && (start2 == LeaveCol);
    gain1    = lv1 && !flag1_q;
    gain2    = lv2 && !flag2_q;
    new_hit  = (blk1 && !flag1_q) || (blk2 && !flag2_q);
    score_nx = score_q;
    if (gain1) score_nx = score_inc(score_nx);
    if (gain2) score_nx = score_inc(score_nx);
    // No pulse once saturated, even though leave events keep arriving.
    scored   = (gain1 || gain2) && (score_q != ScoreMax);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      score_q     <= 8'd0;
      lives_q     <= 2'(LIVES);
      cnt_q       <= '0;
      flag1_q     <= 1'b0;
      flag2_q     <= 1'b0;
      prev1_q     <= 4'd0;
      prev2_q     <= 4'd0;
      collide_q   <= 1'b0;
      score_pt_q  <= 1'b0;
      hit_flash_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      prev1_q    <= start;
      prev2_q    <= start2;
      collide_q  <= 1'b0;
      score_pt_q <= 1'b0;
      if (lv1) flag1_q <= 1'b0;
      if (lv2) flag2_q <= 1'b0;
      unique case (state_q)
        StIdle, StOver: begin
          if (game_start) begin
            state_q     <= StPlay;
            score_q     <= 8'd0;
            lives_q     <= 2'(LIVES);
            flag1_q     <= 1'b0;
            flag2_q     <= 1'b0;
            game_over_q <= 1'b0;
          end
        end
        StPlay: begin
          score_q    <= score_nx;
          score_pt_q <= scored;
          // A blocked lane can never be leaving in the same cycle, so setting
          // its flag here cannot conflict with the leave-clear above.
          if (new_hit) begin
            if (blk1 && !flag1_q) flag1_q <= 1'b1;
            if (blk2 && !flag2_q) flag2_q <= 1'b1;
            collide_q   <= 1'b1;
            lives_q     <= lives_q - 2'd1;
            cnt_q       <= '0;
            hit_flash_q <= 1'b1;
            state_q     <= StHit;
          end
        end
        StHit: begin
          score_q    <= score_nx;
          score_pt_q <= scored;
          if (cnt_q == HitLast) begin
            hit_flash_q <= 1'b0;
            if (lives_q != 2'd0) begin
              state_q <= StPlay;
            end else begin
              state_q     <= StOver;
              game_over_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign collide   = collide_q;
  assign score_pt  = score_pt_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign hit_flash = hit_flash_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_obstacle_collide.sv
// Testbench for obstacle_collide: directed scenarios followed by random play,
// every cycle compared against a behavioural model of the game rules.
module tb_obstacle_collide;

  localparam int HC = 8;
  localparam int PC = 2;
`ifdef COLLIDE_BCD_SCORE_EN
  localparam int SMAX = 99;
  localparam bit BCD  = 1'b1;
`else
  localparam int SMAX = 255;
  localparam bit BCD  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       game_start = 1'b0;
  logic [3:0] start = 4'd2;
  logic [2:0] gap = 3'd0;
  logic [3:0] start2 = 4'd8;
  logic [2:0] gap2 = 3'd0;
  logic [3:0] player_row = 4'd10;
  logic       collide, score_pt, hit_flash, game_over;
  logic [7:0] score;
  logic [1:0] lives;

  always #5 clk = ~clk;

  obstacle_collide #(.HIT_CYCLES(HC)) dut (
    .clk        (clk),
    .reset      (reset),
    .game_start (game_start),
    .start      (start),
    .gap        (gap),
    .start2     (start2),
    .gap2       (gap2),
    .player_row (player_row),
    .collide    (collide),
    .score_pt   (score_pt),
    .score      (score),
    .lives      (lives),
    .hit_flash  (hit_flash),
    .game_over  (game_over)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the game.
  typedef enum {MIdle, MPlay, MHit, MOver} mode_t;
  mode_t m_mode = MIdle;
  int    m_score = 0, m_lives = 3, m_left = 0;
  bit    m_flag[2] = '{1'b0, 1'b0};
  int    m_prev[2] = '{0, 0};
  bit    m_coll = 1'b0, m_pt = 1'b0;

  int cnt_coll, cnt_pt, cnt_flash;

  function automatic bit open_row(int row, int g);
    return (row >= 2 * g) && (row < 2 * g + 4);
  endfunction

  function automatic int disp(int s);
    return BCD ? (s / 10) * 16 + s % 10 : s;
  endfunction

  task automatic model_tick();
    int col[2];
    int g[2];
    bit leave[2];
    bit blocked[2];
    int gain;
    col = '{int'(start), int'(start2)};
    g   = '{int'(gap), int'(gap2)};
    if (reset) begin
      m_mode = MIdle; m_score = 0; m_lives = 3;
      m_flag = '{1'b0, 1'b0}; m_prev = '{0, 0};
      m_coll = 1'b0; m_pt = 1'b0;
      return;
    end
    m_coll = 1'b0;
    m_pt   = 1'b0;
    gain   = 0;
    for (int i = 0; i < 2; i++) begin
      leave[i]   = (m_prev[i] == PC) && (col[i] == (PC + 1) % 16);
      blocked[i] = (col[i] == PC) && !open_row(int'(player_row), g[i]);
    end
    if (m_mode == MPlay || m_mode == MHit) begin
      for (int i = 0; i < 2; i++) if (leave[i] && !m_flag[i]) gain++;
      m_pt    = (gain > 0) && (m_score < SMAX);
      m_score = (m_score + gain > SMAX) ? SMAX : m_score + gain;
    end
    for (int i = 0; i < 2; i++) if (leave[i]) m_flag[i] = 1'b0;
    case (m_mode)
      MIdle, MOver: begin
        if (game_start) begin
          m_mode = MPlay; m_score = 0; m_lives = 3; m_flag = '{1'b0, 1'b0};
        end
      end
      MPlay: begin
        if ((blocked[0] && !m_flag[0]) || (blocked[1] && !m_flag[1])) begin
          for (int i = 0; i < 2; i++) if (blocked[i]) m_flag[i] = 1'b1;
          m_coll  = 1'b1;
          m_lives = m_lives - 1;
          m_mode  = MHit;
          m_left  = HC;
        end
      end
      MHit: begin
        m_left--;
        if (m_left == 0) m_mode = (m_lives > 0) ? MPlay : MOver;
      end
      default: ;
    endcase
    m_prev = col;
  endtask

  task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    check("collide",   32'(collide),   32'(m_coll));
    check("score_pt",  32'(score_pt),  32'(m_pt));
    check("score",     32'(score),     32'(disp(m_score)));
    check("lives",     32'(lives),     32'(m_lives));
    check("hit_flash", 32'(hit_flash), 32'(m_mode == MHit));
    check("game_over", 32'(game_over), 32'(m_mode == MOver));
    cnt_coll  += int'(collide);
    cnt_pt    += int'(score_pt);
    cnt_flash += int'(hit_flash);
  endtask

  task automatic clr_counts();
    cnt_coll = 0; cnt_pt = 0; cnt_flash = 0;
  endtask

  initial begin
    clr_counts();
    // 1. Reset state.
    reset = 1'b1; step(); step();
    reset = 1'b0; step(); step();
    check("t1_lives", 32'(lives), 32'd3);
    check("t1_score", 32'(score), 32'd0);

    // 2. Clean sweep through the player column, then a double leave.
    game_start = 1'b1; step(); game_start = 1'b0;
    gap = 3'd3; player_row = 4'd7; clr_counts();
    for (int s = 0; s < 16; s++) begin
      start = 4'(s); step();
    end
    check("t2_pt_pulses", 32'(cnt_pt), 32'd1);
    check("t2_no_collide", 32'(cnt_coll), 32'd0);
    check("t2_score", 32'(score), 32'(disp(1)));
    gap2 = 3'd3; clr_counts();
    start = 4'd2; start2 = 4'd2; step();
    start = 4'd3; start2 = 4'd3; step();
    start = 4'd4; start2 = 4'd8; step();
    check("t2_double_score", 32'(score), 32'(disp(3)));
    check("t2_double_pulse", 32'(cnt_pt), 32'd1);

    // 3. Column parked on the player: one collision only.
    player_row = 4'd0; start = 4'd2; clr_counts();
    for (int i = 0; i < 20; i++) step();
    check("t3_one_collide", 32'(cnt_coll), 32'd1);
    check("t3_lives", 32'(lives), 32'd2);
    check("t3_flash_len", 32'(cnt_flash), 32'(HC));
    clr_counts();
    start = 4'd3; step();
    start = 4'd4; step();
    check("t3_no_score", 32'(cnt_pt), 32'd0);
    check("t3_score_held", 32'(score), 32'(disp(3)));

    // 4. Both lanes blocked together cost one life; then run out of lives.
    start = 4'd2; start2 = 4'd2; clr_counts();
    for (int i = 0; i < 10; i++) step();
    check("t4_dual_one_hit", 32'(cnt_coll), 32'd1);
    check("t4_lives1", 32'(lives), 32'd1);
    start = 4'd3; start2 = 4'd3; step();
    start = 4'd4; start2 = 4'd8; step();
    start = 4'd2;
    for (int i = 0; i < 10; i++) step();
    check("t4_lives0", 32'(lives), 32'd0);
    check("t4_over", 32'(game_over), 32'd1);
    start = 4'd3; step();
    start = 4'd4; step();
    check("t4_over_score", 32'(score), 32'(disp(3)));
    game_start = 1'b1; step(); game_start = 1'b0;
    check("t4_restart_score", 32'(score), 32'd0);
    check("t4_restart_lives", 32'(lives), 32'd3);
    check("t4_restart_over", 32'(game_over), 32'd0);

    // 5. Saturation.
    player_row = 4'd7; clr_counts();
    for (int i = 0; i < 300; i++) begin
      start = 4'd2; step();
      start = 4'd3; step();
      start = 4'd4; step();
    end
    check("t5_sat_score", 32'(score), 32'(disp(SMAX)));
    check("t5_sat_pulses", 32'(cnt_pt), 32'(SMAX));

    // 6. Reset in the middle of HIT.
    player_row = 4'd0; start = 4'd2;
    step(); step(); step();
    check("t6_in_hit", 32'(hit_flash), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_flash", 32'(hit_flash), 32'd0);
    check("t6_lives", 32'(lives), 32'd3);
    check("t6_score", 32'(score), 32'd0);
    step();
    game_start = 1'b1; step(); game_start = 1'b0;
    player_row = 4'd7; gap = 3'd3;
    start = 4'd3; step();
    check("t6_resume_score", 32'(score), 32'(disp(1)));

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 499) == 0);
      game_start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 0) start = start + 4'd1;
      if ($urandom_range(0, 2) == 0) start2 = start2 + 4'd1;
      if ($urandom_range(0, 99) == 0) start = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) gap = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) gap2 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) player_row = 4'($urandom_range(0, 15));
      step();
    end
    reset = 1'b0; game_start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
